// File: rtl/rggen_adapter_request_stage.sv
// Bus-side request stage: accepts one bus request, drives it onto the register request bus
// and returns exactly one response, including decode-miss and timeout errors.
module rggen_adapter_request_stage #(
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned REGISTERS      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned ERROR_STATUS   = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_bus_valid,
    input  logic [1:0]                     i_bus_access,
    input  logic [ADDRESS_WIDTH-1:0]       i_bus_address,
    input  logic [BUS_WIDTH-1:0]           i_bus_write_data,
    input  logic [BUS_WIDTH/8-1:0]         i_bus_strobe,
    output logic                           o_bus_ready,
    output logic [1:0]                     o_bus_status,
    output logic [BUS_WIDTH-1:0]           o_bus_read_data,
    output logic                           o_register_valid,
    output logic [1:0]                     o_register_access,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int unsigned COUNTER_WIDTH =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic ERROR_BIT = (ERROR_STATUS != 0);

    typedef enum logic [1:0] {
        StIdle,
        StRequest,
        StResponse
    } state_e;

    state_e                   state_q;
    logic [COUNTER_WIDTH-1:0] counter_q;

    logic [REGISTERS-1:0] hit;
    logic [1:0]           hit_status;
    logic [BUS_WIDTH-1:0] hit_data;
    logic                 timeout;
    logic                 done;
    logic [1:0]           done_status;
    logic [BUS_WIDTH-1:0] done_data;

    assign hit = i_register_active & i_register_ready;

    // Decoders never overlap, so OR-merging the completing slots is a plain mux.
    always_comb begin
        hit_status = '0;
        hit_data   = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (hit[i]) begin
                hit_status = hit_status | i_register_status[2*i+:2];
                hit_data   = hit_data | i_register_read_data[BUS_WIDTH*i+:BUS_WIDTH];
            end
        end
    end

    assign timeout = (TIMEOUT_CYCLES != 0) &&
                     (counter_q == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1));

    // Priority: decode miss, then completion (beats a same-cycle timeout), then timeout.
    always_comb begin
        done        = 1'b1;
        done_status = '0;
        done_data   = '0;
        if (i_register_active == '0) begin
            done_status = {ERROR_BIT, 1'b0};
        end else if (hit != '0) begin
            done_status = hit_status;
            if (!o_register_access[0]) begin
                done_data = hit_data;
            end
        end else if (timeout) begin
            done_status = 2'b11;
        end else begin
            done = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q               <= StIdle;
            counter_q             <= '0;
            o_bus_ready           <= 1'b0;
            o_bus_status          <= '0;
            o_bus_read_data       <= '0;
            o_register_valid      <= 1'b0;
            o_register_access     <= '0;
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
        end else begin
            o_bus_ready     <= 1'b0;
            o_bus_status    <= '0;
            o_bus_read_data <= '0;
            case (state_q)
                StIdle: begin
                    if (i_bus_valid) begin
                        state_q               <= StRequest;
                        o_register_valid      <= 1'b1;
                        o_register_access     <= i_bus_access;
                        o_register_address    <= i_bus_address;
                        o_register_write_data <= i_bus_write_data;
                        o_register_strobe     <= i_bus_strobe;
                    end
                end
                StRequest: begin
                    if (done) begin
                        state_q          <= StResponse;
                        o_register_valid <= 1'b0;
                        o_bus_ready      <= 1'b1;
                        o_bus_status     <= done_status;
                        o_bus_read_data  <= done_data;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        counter_q <= counter_q + COUNTER_WIDTH'(1);
                    end
                end
                StResponse: begin
                    state_q   <= StIdle;
                    counter_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
